// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage Y86-64 pipeline: stall/bubble generation,
// run-state sequencing (IDLE/RUN/STOPPED) and saturating performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             running,
    output logic             done,
    output logic [2:0]       cpu_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPOPQ   = 4'd11;
    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_STOPPED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic lu, mp, rt, exm, exw;

    function automatic logic is_exc(input logic [2:0] s);
        return (s == SHLT) || (s == SADR) || (s == SINS);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic            en);
        if (en && (v != '1))
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    always_comb begin
        lu  = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mp  = (E_icode == IJXX) && !e_Cnd;
        rt  = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        exm = is_exc(m_stat);
        exw = is_exc(W_stat);
    end

    always_comb begin
        state_nxt = state;
        F_stall   = 1'b1;
        D_stall   = 1'b0;
        D_bubble  = 1'b1;
        E_bubble  = 1'b1;
        M_bubble  = 1'b1;
        W_stall   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                // load/use wins over ret so D is held rather than bubbled
                F_stall  = lu | rt;
                D_stall  = lu;
                D_bubble = mp | (rt & ~lu);
                E_bubble = mp | lu;
                M_bubble = exm | exw;
                W_stall  = exw;
                if (exw)
                    state_nxt = S_STOPPED;
            end
            S_STOPPED: begin
                W_stall = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cpu_stat     <= SAOK;
            cycle_cnt    <= '0;
            retire_cnt   <= '0;
            lu_stall_cnt <= '0;
            mispred_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_RUN) begin
                cycle_cnt    <= sat_inc(cycle_cnt, 1'b1);
                retire_cnt   <= sat_inc(retire_cnt, W_stat == SAOK);
                lu_stall_cnt <= sat_inc(lu_stall_cnt, lu);
                mispred_cnt  <= sat_inc(mispred_cnt, mp);
                if (exw)
                    cpu_stat <= W_stat;
            end
        end
    end

    assign running = (state == S_RUN);
    assign done    = (state == S_STOPPED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the control rules.
module tb_pipe_ctrl;

    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [3:0]    D_icode;
    logic [3:0]    d_srcA;
    logic [3:0]    d_srcB;
    logic [3:0]    E_icode;
    logic [3:0]    E_dstM;
    logic          e_Cnd;
    logic [3:0]    M_icode;
    logic [2:0]    m_stat;
    logic [2:0]    W_stat;
    logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic          running, done;
    logic [2:0]    cpu_stat;
    logic [CW-1:0] cycle_cnt, retire_cnt, lu_stall_cnt, mispred_cnt;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .running(running), .done(done), .cpu_stat(cpu_stat),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .lu_stall_cnt(lu_stall_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model: mode 0 idle, 1 run, 2 stopped
    int          m_mode;
    int          m_stat_q;
    int unsigned m_cyc, m_ret, m_lu, m_mp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_exc(input int s);
        return (s == 2) || (s == 3) || (s == 4);
    endfunction

    function automatic int unsigned bump(input int unsigned v, input bit en);
        return (en && v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_stat_q = 1;
        m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0;
    endtask

    task automatic set_defaults();
        start = 0; D_icode = 4'd1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'd1; E_dstM = 4'hF; e_Cnd = 0; M_icode = 4'd1;
        m_stat = 3'd1; W_stat = 3'd1;
    endtask

    task automatic step();
        bit lu, mp, rt, exm, exw;
        logic [5:0] ctl;
        @(negedge clk);
        lu  = (E_icode == 5 || E_icode == 11) && E_dstM != 4'hF &&
              (E_dstM == d_srcA || E_dstM == d_srcB);
        mp  = (E_icode == 7) && !e_Cnd;
        rt  = (D_icode == 9) || (E_icode == 9) || (M_icode == 9);
        exm = is_exc(int'(m_stat));
        exw = is_exc(int'(W_stat));
        if (m_mode == 0)      ctl = 6'b101110;
        else if (m_mode == 2) ctl = 6'b101111;
        else ctl = {lu | rt, lu, mp | (rt & !lu), mp | lu, exm | exw, exw};
        check("ctl", {26'b0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, {26'b0, ctl});
        check("dstall_and_dbubble", {31'b0, D_stall & D_bubble}, 32'd0);
        check("running", {31'b0, running}, (m_mode == 1) ? 32'd1 : 32'd0);
        check("done", {31'b0, done}, (m_mode == 2) ? 32'd1 : 32'd0);
        check("cpu_stat", {29'b0, cpu_stat}, m_stat_q);
        check("cycle_cnt", {28'b0, cycle_cnt}, m_cyc);
        check("retire_cnt", {28'b0, retire_cnt}, m_ret);
        check("lu_stall_cnt", {28'b0, lu_stall_cnt}, m_lu);
        check("mispred_cnt", {28'b0, mispred_cnt}, m_mp);
        if (rst) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            m_cyc = bump(m_cyc, 1);
            m_ret = bump(m_ret, W_stat == 3'd1);
            m_lu  = bump(m_lu, lu);
            m_mp  = bump(m_mp, mp);
            if (exw) begin
                m_mode   = 2;
                m_stat_q = int'(W_stat);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rnd_icode();
        case ($urandom_range(0, 7))
            0: return 4'd5;
            1: return 4'd11;
            2: return 4'd7;
            3: return 4'd9;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    function automatic logic [2:0] rnd_stat(input int unsigned exc_odds);
        int unsigned r;
        r = $urandom_range(0, exc_odds - 1);
        if (r == 0) return 3'($urandom_range(2, 4));
        if (r < exc_odds / 4) return 3'd0;
        return 3'd1;
    endfunction

    initial begin
        set_defaults();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();

        // idle cycles then a start pulse
        step();
        rst = 0;
        step(); step();
        start = 1; step();
        start = 0; step();

        // load/use hazard, then same with no destination
        E_icode = 4'd5; E_dstM = 4'd2; d_srcA = 4'd2; step();
        E_dstM = 4'hF; step();
        set_defaults();

        // mispredicted and correctly predicted jump
        E_icode = 4'd7; e_Cnd = 0; step();
        e_Cnd = 1; step();
        set_defaults();

        // ret in decode, then ret combined with load/use
        D_icode = 4'd9;
        repeat (3) step();
        E_icode = 4'd5; E_dstM = 4'd3; d_srcB = 4'd3; step();
        set_defaults();

        // address fault through M then W; start after stop is ignored
        m_stat = 3'd3; step();
        m_stat = 3'd1; W_stat = 3'd3; step();
        W_stat = 3'd1; step();
        check("stop_done", {31'b0, done}, 32'd1);
        check("stop_stat", {29'b0, cpu_stat}, 32'd3);
        start = 1; step();
        start = 0; step();

        // retirement counter saturation
        rst = 1; step();
        rst = 0; start = 1; step();
        start = 0;
        repeat (20) step();
        check("retire_sat", {28'b0, retire_cnt}, CMAX);
        repeat (2) step();

        // reset mid-run clears everything
        rst = 1; step();
        rst = 0;
        check("rst_cycle_cnt", {28'b0, cycle_cnt}, 32'd0);
        check("rst_running", {31'b0, running}, 32'd0);
        step();

        // randomized segments
        for (int seg = 0; seg < 60; seg++) begin
            rst = 1; start = 0; step();
            rst = 0; start = 1; step();
            for (int c = 0; c < 25; c++) begin
                start   = ($urandom_range(0, 9) == 0);
                rst     = ($urandom_range(0, 59) == 0);
                D_icode = rnd_icode();
                d_srcA  = rnd_reg();
                d_srcB  = rnd_reg();
                E_icode = rnd_icode();
                E_dstM  = rnd_reg();
                e_Cnd   = 1'($urandom_range(0, 1));
                M_icode = rnd_icode();
                m_stat  = rnd_stat(15);
                W_stat  = rnd_stat(30);
                step();
            end
            set_defaults();
            rst = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
